retire_monitor: RTL and testbench

RETIRE_MONITOR -- requirements
Module: retire_monitor

---
 rtl/parameter_pkg.sv | 7 +
 rtl/typedef_pkg.sv | 11 +
 rtl/trace_fifo.sv | 70 +++++++
 rtl/retire_monitor.sv | 159 +++++++++++++++
 tb/tb_retire_monitor.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/parameter_pkg.sv
// Shared default sizing for the retire monitor and its trace buffer.
package parameter_pkg;

    localparam int RETIRE_WIDTH_DEF = 2;
    localparam int TRACE_DEPTH_DEF  = 16;

endpackage

// File: rtl/typedef_pkg.sv
// Shared types for the retire monitor.
package typedef_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } monitor_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Multi-push, single-pop FIFO. Each cycle it accepts the lowest-numbered
// valid push lanes that fit. A pop in the same cycle frees one slot for
// those pushes.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int NPUSH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPUSH-1:0]       push_valid,
    input  logic [NPUSH*WIDTH-1:0] push_data,
    input  logic                   pop,
    output logic [NPUSH-1:0]       push_accept,
    output logic                   rd_valid,
    output logic [WIDTH-1:0]       rd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_P   = (PW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d, rd_q, rd_d, occ, free, n_push;
    logic [PW-1:0]    slot [NPUSH];
    logic             pop_en;

    // The extra pointer bit gives exact occupancy, so full and empty are unambiguous.
    assign occ      = wr_q - rd_q;
    assign rd_valid = (occ != '0);
    assign pop_en   = pop && rd_valid;
    assign rd_data  = mem_q[rd_q[PW-1:0]];

    // Assign consecutive slots to accepted lanes in ascending lane order.
    always_comb begin
        free        = DEPTH_P - occ + (pop_en ? ONE_P : '0);
        n_push      = '0;
        push_accept = '0;
        for (int i = 0; i < NPUSH; i++) begin
            slot[i] = '0;
            if (push_valid[i] && (n_push < free)) begin
                push_accept[i] = 1'b1;
                slot[i]        = wr_q[PW-1:0] + n_push[PW-1:0];
                n_push         = n_push + ONE_P;
            end
        end
        wr_d = wr_q + n_push;
        rd_d = rd_q + (pop_en ? ONE_P : '0);
    end

    // Storage is not reset; resetting the pointers discards any stale contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPUSH; i++) begin
            if (push_accept[i]) begin
                mem_q[slot[i]] <= push_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

endmodule

// File: rtl/retire_monitor.sv
// Watches CPU retirement. It counts run cycles, retires and dropped trace
// entries, detects program completion, budget timeout and stall, and buffers
// {pc, cycle} trace records for a downstream reader.
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for enable
// RUN     | counting cycles/retires, pushing trace records
// DONE    | CPU reported done; terminal until rst, trace drains
// TIMEOUT | budget spent or stall (see stalled); terminal
module retire_monitor
    import typedef_pkg::*;
    import parameter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int RETIRE_WIDTH = RETIRE_WIDTH_DEF,
    parameter int TRACE_DEPTH  = TRACE_DEPTH_DEF,
    parameter int CNT_WIDTH    = 32,
    parameter int MAX_CYCLES   = 30000,
    parameter int STALL_LIMIT  = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               done,
    input  logic [RETIRE_WIDTH-1:0]            retire_valid,
    input  logic [RETIRE_WIDTH*ADDR_WIDTH-1:0] retire_addr,
    output logic [1:0]                         state,
    output logic                               stalled,
    output logic                               halt,
    output logic [CNT_WIDTH-1:0]               cycle_count,
    output logic [CNT_WIDTH-1:0]               retire_count,
    output logic [CNT_WIDTH-1:0]               drop_count,
    output logic                               trace_valid,
    input  logic                               trace_ready,
    output logic [ADDR_WIDTH-1:0]              trace_addr,
    output logic [CNT_WIDTH-1:0]               trace_cycle
);
    localparam int ENTRY_W = ADDR_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] BUDGET_LAST = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STALL_LAST  = CNT_WIDTH'(STALL_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    monitor_state_t state_q, state_d;
    logic stalled_q, stalled_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d, idle_q, idle_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d, drop_q, drop_d;
    logic [CNT_WIDTH-1:0] n_valid, n_pushed;
    logic in_run, any_retire, budget_hit, stall_hit;
    logic [RETIRE_WIDTH-1:0] push_valid, push_accept;
    logic [RETIRE_WIDTH*ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [RETIRE_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) n = n + CNT_WIDTH'(v[i]);
        return n;
    endfunction

    assign in_run     = (state_q == ST_RUN);
    assign any_retire = |retire_valid;
    assign budget_hit = (cycle_q == BUDGET_LAST);
    assign stall_hit  = !any_retire && (idle_q == STALL_LAST);
    assign push_valid = retire_valid & {RETIRE_WIDTH{in_run}};
    assign n_valid    = popcount(push_valid);
    assign n_pushed   = popcount(push_accept);

    // Next-state logic: done beats budget timeout, and budget timeout beats stall.
    always_comb begin
        state_d   = state_q;
        stalled_d = stalled_q;
        case (state_q)
            ST_IDLE: if (enable) state_d = ST_RUN;
            ST_RUN: begin
                if (done) begin
                    state_d = ST_DONE;
                end else if (budget_hit) begin
                    state_d = ST_TIMEOUT;
                end else if (stall_hit) begin
                    state_d   = ST_TIMEOUT;
                    stalled_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Counter updates. The terminating RUN cycle still counts its cycle and its retires.
    always_comb begin
        cycle_d = cycle_q;
        idle_d  = idle_q;
        if (in_run) begin
            if (cycle_q != '1) cycle_d = cycle_q + CNT_ONE;
            idle_d = any_retire ? '0 : idle_q + CNT_ONE;
        end
        retire_d = sat_add(retire_q, n_valid);
        drop_d   = sat_add(drop_q, n_valid - n_pushed);
    end

    // Pack one {pc, cycle} record per retire lane.
    always_comb begin
        push_data = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            push_data[i*ENTRY_W +: ENTRY_W] = {retire_addr[i*ADDR_WIDTH +: ADDR_WIDTH], cycle_q};
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stalled_q <= 1'b0;
            cycle_q   <= '0;
            idle_q    <= '0;
            retire_q  <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            stalled_q <= stalled_d;
            cycle_q   <= cycle_d;
            idle_q    <= idle_d;
            retire_q  <= retire_d;
            drop_q    <= drop_d;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TRACE_DEPTH),
        .NPUSH (RETIRE_WIDTH)
    ) u_trace_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_valid  (push_valid),
        .push_data   (push_data),
        .pop         (trace_ready),
        .push_accept (push_accept),
        .rd_valid    (trace_valid),
        .rd_data     (head)
    );

    assign state        = state_q;
    assign stalled      = stalled_q;
    assign halt         = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign drop_count   = drop_q;
    assign trace_addr   = head[ENTRY_W-1 -: ADDR_WIDTH];
    assign trace_cycle  = head[CNT_WIDTH-1:0];

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor. It uses a small-budget configuration so that
// timeout, stall and FIFO-full cases are reachable in a few cycles.
module tb_retire_monitor;
    localparam int AW = 32, RW = 2, DEP = 4, CW = 32, MAXC = 50, STL = 8;

    logic clk = 1'b0;
    logic rst, enable, done, trace_ready;
    logic [RW-1:0] retire_valid;
    logic [RW*AW-1:0] retire_addr;
    logic [1:0] state;
    logic stalled, halt, trace_valid;
    logic [CW-1:0] cycle_count, retire_count, drop_count, trace_cycle;
    logic [AW-1:0] trace_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retire_monitor #(
        .ADDR_WIDTH(AW), .RETIRE_WIDTH(RW), .TRACE_DEPTH(DEP),
        .CNT_WIDTH(CW), .MAX_CYCLES(MAXC), .STALL_LIMIT(STL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .done(done),
        .retire_valid(retire_valid), .retire_addr(retire_addr),
        .state(state), .stalled(stalled), .halt(halt),
        .cycle_count(cycle_count), .retire_count(retire_count), .drop_count(drop_count),
        .trace_valid(trace_valid), .trace_ready(trace_ready),
        .trace_addr(trace_addr), .trace_cycle(trace_cycle)
    );

    // Reference model: a queue of trace records plus plain integer counters.
    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } ent_t;
    ent_t mq[$];
    int m_state, m_cycle, m_ret, m_drop, m_streak;
    bit m_stalled;

    function automatic void model_step();
        int nv;
        ent_t e;
        if (rst) begin
            m_state = 0; m_stalled = 0; m_cycle = 0; m_ret = 0; m_drop = 0; m_streak = 0;
            mq.delete();
            return;
        end
        if (trace_ready && mq.size() > 0) void'(mq.pop_front());
        if (m_state == 1) begin
            nv = 0;
            for (int ch = 0; ch < RW; ch++) begin
                if (retire_valid[ch]) begin
                    nv++;
                    if (mq.size() < DEP) begin
                        e.addr = retire_addr[ch*AW +: AW];
                        e.cyc  = m_cycle;
                        mq.push_back(e);
                    end else begin
                        m_drop++;
                    end
                end
            end
            m_ret += nv;
            m_streak = (nv == 0) ? m_streak + 1 : 0;
            if (done) m_state = 2;
            else if (m_cycle + 1 == MAXC) m_state = 3;
            else if (m_streak == STL) begin
                m_state = 3;
                m_stalled = 1;
            end
            m_cycle++;
        end else if (m_state == 0 && enable) begin
            m_state = 1;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string nm);
        chk({nm, "_state"}, 64'(state), 64'(m_state));
        chk({nm, "_stalled"}, 64'(stalled), 64'(m_stalled));
        chk({nm, "_halt"}, 64'(halt), 64'(m_state >= 2));
        chk({nm, "_cycle"}, 64'(cycle_count), 64'(m_cycle));
        chk({nm, "_retire"}, 64'(retire_count), 64'(m_ret));
        chk({nm, "_drop"}, 64'(drop_count), 64'(m_drop));
        chk({nm, "_tvalid"}, 64'(trace_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({nm, "_taddr"}, 64'(trace_addr), 64'(mq[0].addr));
            chk({nm, "_tcyc"}, 64'(trace_cycle), 64'(mq[0].cyc));
        end
    endtask

    typedef struct {
        logic rst, en, dn, rdy;
        logic [1:0] rv;
        logic [31:0] a0, a1;
        logic [1:0] e_state;
        logic [31:0] e_cyc, e_ret, e_drop;
        logic e_tv;
        logic [31:0] e_taddr, e_tcyc;
    } vec_t;

    function automatic vec_t mkv(int r, int en, int dn, int rv, int a0, int a1, int rdy,
                                 int es, int ec, int er, int ed, int tv, int ta, int tc);
        vec_t v;
        v.rst = r[0]; v.en = en[0]; v.dn = dn[0]; v.rv = rv[1:0];
        v.a0 = a0; v.a1 = a1; v.rdy = rdy[0];
        v.e_state = es[1:0]; v.e_cyc = ec; v.e_ret = er; v.e_drop = ed;
        v.e_tv = tv[0]; v.e_taddr = ta; v.e_tcyc = tc;
        return v;
    endfunction

    // Runs one program from reset until halt. Lane 0 retires PC 4*k while
    // k < retire_until, and done is raised on run cycle done_at.
    task automatic run_program(input string nm, input int retire_until, input int done_at,
                               input int e_state, input int e_cyc, input int e_stalled,
                               input int e_ret);
        int k;
        rst = 1; enable = 0; done = 0; retire_valid = '0; retire_addr = '0; trace_ready = 1;
        tick();
        compare_model({nm, "_rst"});
        rst = 0; enable = 1;
        tick();
        compare_model({nm, "_en"});
        enable = 0;
        k = 0;
        while (!halt && k < 70) begin
            retire_valid = (k < retire_until) ? 2'b01 : 2'b00;
            retire_addr  = {$urandom, 32'(4 * k)};
            done         = (k == done_at);
            tick();
            compare_model({nm, "_run"});
            k++;
        end
        done = 0;
        chk({nm, "_final_state"}, 64'(state), 64'(e_state));
        chk({nm, "_final_cycle"}, 64'(cycle_count), 64'(e_cyc));
        chk({nm, "_final_stalled"}, 64'(stalled), 64'(e_stalled));
        chk({nm, "_final_retire"}, 64'(retire_count), 64'(e_ret));
        chk({nm, "_halt_latency"}, 64'(k), 64'(e_cyc));
        retire_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            compare_model({nm, "_post"});
        end
        chk({nm, "_post_retire"}, 64'(retire_count), 64'(e_ret));
        retire_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [10];
        rst = 1; enable = 0; done = 0; trace_ready = 0; retire_valid = '0; retire_addr = '0;

        vt[0] = mkv(1,0,0,0,0,0,0,                 0,0,0,0,0,0,0);
        vt[1] = mkv(0,1,0,3,'h200,'h204,0,         1,0,0,0,0,0,0);
        vt[2] = mkv(0,0,0,3,'h100,'h104,0,         1,1,2,0,1,'h100,0);
        vt[3] = mkv(0,0,0,3,'h108,'h10C,0,         1,2,4,0,1,'h100,0);
        vt[4] = mkv(0,0,0,3,'h110,'h114,0,         1,3,6,2,1,'h100,0);
        vt[5] = mkv(0,0,0,1,'h118,'h11C,1,         1,4,7,2,1,'h104,0);
        vt[6] = mkv(0,0,0,0,0,0,1,                 1,5,7,2,1,'h108,1);
        vt[7] = mkv(0,0,0,0,0,0,0,                 1,6,7,2,1,'h108,1);
        vt[8] = mkv(1,1,0,3,'h300,'h304,1,         0,0,0,0,0,0,0);
        vt[9] = mkv(0,0,0,3,'h300,'h304,1,         0,0,0,0,0,0,0);

        for (int i = 0; i < 10; i++) begin
            rst = vt[i].rst; enable = vt[i].en; done = vt[i].dn; trace_ready = vt[i].rdy;
            retire_valid = vt[i].rv; retire_addr = {vt[i].a1, vt[i].a0};
            tick();
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vt[i].e_state));
            chk($sformatf("vec%0d_cycle", i), 64'(cycle_count), 64'(vt[i].e_cyc));
            chk($sformatf("vec%0d_retire", i), 64'(retire_count), 64'(vt[i].e_ret));
            chk($sformatf("vec%0d_drop", i), 64'(drop_count), 64'(vt[i].e_drop));
            chk($sformatf("vec%0d_tvalid", i), 64'(trace_valid), 64'(vt[i].e_tv));
            chk($sformatf("vec%0d_halt", i), 64'(halt), 64'(0));
            if (vt[i].e_tv) begin
                chk($sformatf("vec%0d_taddr", i), 64'(trace_addr), 64'(vt[i].e_taddr));
                chk($sformatf("vec%0d_tcyc", i), 64'(trace_cycle), 64'(vt[i].e_tcyc));
            end
        end

        run_program("done10",        100, 10, 2, 11, 0, 11);
        run_program("budget",        100, -1, 3, 50, 0, 50);
        run_program("stall",           3, -1, 3, 11, 1, 3);
        run_program("done_vs_stall",   3, 10, 2, 11, 0, 3);
        run_program("budget_vs_stall",42, -1, 3, 50, 0, 42);
        run_program("done_vs_budget",100, 49, 2, 50, 0, 50);

        for (int p = 0; p < 40; p++) begin
            rst = 1; enable = 0; done = 0; retire_valid = '0; trace_ready = 0;
            tick();
            compare_model("rand_rst");
            rst = 0;
            for (int c = 0; c < 80; c++) begin
                enable       = ($urandom_range(0, 2) == 0);
                done         = ($urandom_range(0, 29) == 0);
                retire_valid = (p % 4 == 0) ? RW'($urandom_range(0, 3) == 0) : RW'($urandom);
                retire_addr  = {$urandom, $urandom};
                trace_ready  = ($urandom_range(0, 2) != 0);
                rst          = ($urandom_range(0, 149) == 0);
                tick();
                compare_model("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
